// File: rtl/full_subtractor_from_hs.sv
// Registered ripple-borrow subtractor: diff/bout = a - b - bin, built from
// half-subtractor cells (two per bit plus an OR for the borrow).

module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module full_subtractor_from_hs #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid
);
  // borrow[i] is the borrow into bit i; borrow[WIDTH] is the final borrow-out
  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] bo1;
  logic [WIDTH-1:0] bo2;
  logic [WIDTH-1:0] diff_next;
  logic             bout_next;

  assign borrow[0] = bin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      half_subtractor hs1 (
        .x  (a[gi]),
        .y  (b[gi]),
        .d  (d1[gi]),
        .bo (bo1[gi])
      );
      half_subtractor hs2 (
        .x  (d1[gi]),
        .y  (borrow[gi]),
        .d  (diff_next[gi]),
        .bo (bo2[gi])
      );
      assign borrow[gi+1] = bo1[gi] | bo2[gi];
    end
  endgenerate

  assign bout_next = borrow[WIDTH];

  // Result holds when no operand set is offered; only out_valid drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff      <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff <= diff_next;
        bout <= bout_next;
      end
    end
  end
endmodule

// File: tb/tb_full_subtractor_from_hs.sv
// Directed and randomized checks of full_subtractor_from_hs at WIDTH=1 and WIDTH=8.

module tb_full_subtractor_from_hs;
  logic       clk;
  logic       rst_n;
  logic       v1, a1, b1, bin1;
  logic       d1, bo1, ov1;
  logic       v8, bin8;
  logic [7:0] a8, b8;
  logic [7:0] d8;
  logic       bo8, ov8;

  int checks;
  int failures;

  full_subtractor_from_hs #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1),
    .a         (a1),
    .b         (b1),
    .bin       (bin1),
    .diff      (d1),
    .bout      (bo1),
    .out_valid (ov1)
  );

  full_subtractor_from_hs #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v8),
    .a         (a8),
    .b         (b8),
    .bin       (bin8),
    .diff      (d8),
    .bout      (bo8),
    .out_valid (ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_w1(input string tag, input logic ed, input logic eb, input logic ev);
    check_eq({tag, ".diff"}, {63'd0, d1}, {63'd0, ed});
    check_eq({tag, ".bout"}, {63'd0, bo1}, {63'd0, eb});
    check_eq({tag, ".out_valid"}, {63'd0, ov1}, {63'd0, ev});
  endtask

  task automatic check_w8(input string tag, input logic [7:0] ed, input logic eb, input logic ev);
    check_eq({tag, ".diff"}, {56'd0, d8}, {56'd0, ed});
    check_eq({tag, ".bout"}, {63'd0, bo8}, {63'd0, eb});
    check_eq({tag, ".out_valid"}, {63'd0, ov8}, {63'd0, ev});
  endtask

  // Drive one WIDTH=1 operand set, clock it in, check the registered result
  task automatic step1(input string tag, input logic a, input logic b, input logic bn, input logic v,
                       input logic ed, input logic eb, input logic ev);
    a1 = a; b1 = b; bin1 = bn; v1 = v; v8 = 1'b0;
    @(posedge clk); #1;
    check_w1(tag, ed, eb, ev);
    $display("w1 %s a=%0d b=%0d bin=%0d v=%0d -> diff=%0d bout=%0d ov=%0d", tag, a, b, bn, v, d1, bo1, ov1);
  endtask

  task automatic step8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bn,
                       input logic [7:0] ed, input logic eb);
    a8 = a; b8 = b; bin8 = bn; v8 = 1'b1; v1 = 1'b0;
    @(posedge clk); #1;
    check_w8(tag, ed, eb, 1'b1);
    $display("w8 %s a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d ov=%0d", tag, a, b, bn, d8, bo8, ov8);
  endtask

  // Randomized back-to-back run on both widths against an arithmetic reference
  task automatic random_run(input string tag, input int n, input bit always_valid);
    logic [1:0] ref1;
    logic [8:0] ref8;
    logic       ed1, eb1, ev1, eb8, ev8;
    logic [7:0] ed8;
    ed1 = d1; eb1 = bo1; ed8 = d8; eb8 = bo8;
    for (int i = 0; i < n; i++) begin
      a1 = 1'($urandom_range(1)); b1 = 1'($urandom_range(1)); bin1 = 1'($urandom_range(1));
      a8 = 8'($urandom_range(255)); b8 = 8'($urandom_range(255)); bin8 = 1'($urandom_range(1));
      v1 = always_valid ? 1'b1 : ($urandom_range(3) != 0);
      v8 = always_valid ? 1'b1 : ($urandom_range(3) != 0);
      ref1 = {1'b0, a1} - {1'b0, b1} - {1'b0, bin1};
      ref8 = {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
      if (v1) begin ed1 = ref1[0]; eb1 = ref1[1]; end
      if (v8) begin ed8 = ref8[7:0]; eb8 = ref8[8]; end
      ev1 = v1; ev8 = v8;
      @(posedge clk); #1;
      check_w1({tag, ".w1"}, ed1, eb1, ev1);
      check_w8({tag, ".w8"}, ed8, eb8, ev8);
    end
    $display("%s cycles=%0d checks=%0d failures=%0d", tag, n, checks, failures);
  endtask

  logic [2:0] ex_in  [8];
  logic [1:0] ex_out [8];

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
    v8 = 1'b0; a8 = 8'd0; b8 = 8'd0; bin8 = 1'b0;

    #2;
    check_w1("reset_init", 1'b0, 1'b0, 1'b0);
    check_w8("reset_init", 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in mid-cycle with a live operand set
    step1("pre_reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check_w1("reset_async", 1'b0, 1'b0, 1'b0);
    $display("reset asserted mid-cycle -> diff=%0d bout=%0d ov=%0d", d1, bo1, ov1);
    @(posedge clk); #1;
    check_w1("reset_held_edge", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_w1("reset_released", 1'b0, 1'b0, 1'b0);
    step1("post_reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // WIDTH=1 truth table: {a,b,bin} -> {diff,bout}
    ex_in[0] = 3'b000; ex_out[0] = 2'b00;
    ex_in[1] = 3'b001; ex_out[1] = 2'b11;
    ex_in[2] = 3'b010; ex_out[2] = 2'b11;
    ex_in[3] = 3'b011; ex_out[3] = 2'b01;
    ex_in[4] = 3'b100; ex_out[4] = 2'b10;
    ex_in[5] = 3'b101; ex_out[5] = 2'b00;
    ex_in[6] = 3'b110; ex_out[6] = 2'b00;
    ex_in[7] = 3'b111; ex_out[7] = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step1($sformatf("fs_%0d", i), ex_in[i][2], ex_in[i][1], ex_in[i][0], 1'b1,
            ex_out[i][1], ex_out[i][0], 1'b1);
    end

    // Hold: result of (1,0,0) must survive changing inputs while in_valid is low
    step1("hold_load", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step1("hold_0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step1("hold_1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step1("hold_2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // WIDTH=8 ripple and boundary vectors, back-to-back
    step8("ripple_00_00_1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    step8("ripple_80_01_0", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    step8("bound_FF_FF_1",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    step8("bound_FF_00_0",  8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
    step8("bound_05_05_0",  8'h05, 8'h05, 1'b0, 8'h00, 1'b0);
    step8("mixed_3C_5A_1",  8'h3C, 8'h5A, 1'b1, 8'hE1, 1'b1);

    random_run("rand_b2b", 1000, 1'b1);
    random_run("rand_gap", 300, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
